// File: rtl/paired_word_ram_pkg.sv
// Shared types and helpers for paired_word_ram.
// Optional build macro: PAIRED_WORD_RAM_BYPASS_EN (write-first same-pair reads).
package paired_word_ram_pkg;

  localparam int DEF_WORD_W = 10;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Even-aligned base address of the pair containing a word address.
  function automatic logic [31:0] pair_base(input logic [31:0] address);
    return {address[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/paired_word_ram_clear_fsm.sv
// Post-reset clear sequencer: walks every pair once, then idles until the next reset.
//
//   state | meaning
//   CLEAR | writing CLEAR_VAL to pair at ptr each cycle; busy=1
//   IDLE  | array released to user traffic; no exit except rst
module paired_word_ram_clear_fsm
  import paired_word_ram_pkg::*;
#(
  parameter int PTR_W = DEF_ADDR_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             busy,
  output logic             clr_we,
  output logic [PTR_W-1:0] clr_ptr
);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy    = 1'b0;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        // Pointer parks on the last pair; it is never reused in IDLE.
        if (ptr_q == {PTR_W{1'b1}}) state_d = IDLE;
        else                        ptr_d   = ptr_q + 1'b1;
      end
      IDLE: begin
      end
    endcase
  end

  assign clr_ptr = ptr_q;

endmodule

// File: rtl/paired_word_ram.sv
// Single-port word RAM with aligned pair reads, single/pair writes and a hardware clear after reset.
// Optional build macro: PAIRED_WORD_RAM_BYPASS_EN (same-pair read returns write-merged data).
module paired_word_ram
  import paired_word_ram_pkg::*;
#(
  parameter int                WORD_W    = DEF_WORD_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [WORD_W-1:0] CLEAR_VAL = {WORD_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                wpair,
  input  logic                re,
  input  logic [ADDR_W-1:0]   address,
  input  logic [2*WORD_W-1:0] wdata,
  output logic [2*WORD_W-1:0] rdata,
  output logic                rvalid,
  output logic                busy
);

  localparam int PTR_W = ADDR_W - 1;
  localparam int PAIRS = 2 ** PTR_W;

  // Storage split into even and odd banks indexed by pair, so a pair access is one row.
  logic [WORD_W-1:0] ram_even [PAIRS];
  logic [WORD_W-1:0] ram_odd  [PAIRS];

  logic             clr_we;
  logic [PTR_W-1:0] clr_ptr;

  paired_word_ram_clear_fsm #(.PTR_W(PTR_W)) u_clear_fsm (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_ptr (clr_ptr)
  );

  logic [31:0]      base_full;
  logic [PTR_W-1:0] pidx;
  logic             unused_base_bits;

  assign base_full        = pair_base(32'(address));
  assign pidx             = base_full[ADDR_W-1:1];
  assign unused_base_bits = ^{base_full[31:ADDR_W], base_full[0]};

  logic              user_we, user_even, user_odd;
  logic [WORD_W-1:0] user_even_d, user_odd_d;

  assign user_we     = we & ~busy;
  assign user_even   = user_we & (wpair | ~address[0]);
  assign user_odd    = user_we & (wpair | address[0]);
  assign user_even_d = wdata[WORD_W-1:0];
  // A single-word write to an odd address still takes its data from the low half.
  assign user_odd_d  = wpair ? wdata[2*WORD_W-1:WORD_W] : wdata[WORD_W-1:0];

  logic              wr_even, wr_odd;
  logic [PTR_W-1:0]  wr_idx;
  logic [WORD_W-1:0] wr_even_d, wr_odd_d;

  always_comb begin
    wr_even   = user_even;
    wr_odd    = user_odd;
    wr_idx    = pidx;
    wr_even_d = user_even_d;
    wr_odd_d  = user_odd_d;
    if (clr_we) begin
      wr_even   = 1'b1;
      wr_odd    = 1'b1;
      wr_idx    = clr_ptr;
      wr_even_d = CLEAR_VAL;
      wr_odd_d  = CLEAR_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_even) ram_even[wr_idx] <= wr_even_d;
    if (wr_odd)  ram_odd[wr_idx]  <= wr_odd_d;
  end

  logic              rd_en;
  logic [WORD_W-1:0] rd_even, rd_odd;

  assign rd_en = re & ~busy;

  always_comb begin
    rd_even = ram_even[pidx];
    rd_odd  = ram_odd[pidx];
`ifdef PAIRED_WORD_RAM_BYPASS_EN
    if (user_even) rd_even = user_even_d;
    if (user_odd)  rd_odd  = user_odd_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) rdata <= {rd_odd, rd_even};
    end
  end

endmodule

// File: tb/tb_paired_word_ram.sv
// Directed bench for paired_word_ram with a model-fed expected-read queue.
// Honours PAIRED_WORD_RAM_BYPASS_EN to pick the same-pair read expectation.
module tb_paired_word_ram;

  localparam int W  = 10;
  localparam int AW = 10;
  localparam int CLEAR_CYCLES = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0, wpair = 1'b0, re = 1'b0;
  logic [AW-1:0] address = '0;
  logic [2*W-1:0] wdata = '0;
  logic [2*W-1:0] rdata;
  logic          rvalid, busy;

  paired_word_ram dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wpair   (wpair),
    .re      (re),
    .address (address),
    .wdata   (wdata),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] expq[$];
  logic [W-1:0]   mdl [1 << AW];
  bit clearing = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Any rvalid must match the oldest outstanding read; an rvalid with nothing pending is a failure.
  always @(negedge clk) begin
    if (rst === 1'b0 && rvalid === 1'b1) begin
      if (expq.size() == 0) check("spurious_rvalid", 32'(rvalid), 32'd0);
      else                  check("rdata", 32'(rdata), 32'(expq.pop_front()));
    end
  end

  task automatic mwrite(input bit w, input bit wp, input logic [AW-1:0] a, input logic [2*W-1:0] d);
    if (w) begin
      if (wp) begin
        mdl[{a[AW-1:1], 1'b0}] = d[W-1:0];
        mdl[{a[AW-1:1], 1'b1}] = d[2*W-1:W];
      end else begin
        mdl[a] = d[W-1:0];
      end
    end
  endtask

  task automatic mread(input bit r, input logic [AW-1:0] a);
    if (r) expq.push_back({mdl[{a[AW-1:1], 1'b1}], mdl[{a[AW-1:1], 1'b0}]});
  endtask

  task automatic cyc(input bit w, input bit wp, input bit r, input logic [AW-1:0] a,
                     input logic [2*W-1:0] d);
    we = w; wpair = wp; re = r; address = a; wdata = d;
    if (!clearing) begin
`ifdef PAIRED_WORD_RAM_BYPASS_EN
      mwrite(w, wp, a, d);
      mread(r, a);
`else
      mread(r, a);
      mwrite(w, wp, a, d);
`endif
    end
    @(posedge clk); #1;
    we = 1'b0; wpair = 1'b0; re = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; we = 1'b0; re = 1'b0; wpair = 1'b0;
    clearing = 1'b1;
    expq.delete();
    #2;
    check({tag, "_rdata"},  32'(rdata),  32'd0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_busy"},   32'(busy),   32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mdl[i] = '0;
  endtask

  // Runs the clear; optionally injects a request at one cycle or stops early for a reset.
  task automatic clear_run(input int inject, input int abort);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (i == inject) begin
        we = 1'b1; re = 1'b1; wpair = 1'b1; address = 10'd20; wdata = 20'hABCDE;
      end
      @(posedge clk); #1;
      we = 1'b0; re = 1'b0; wpair = 1'b0;
      cnt++;
      if (i == inject) check("rvalid_during_clear", 32'(rvalid), 32'd0);
      if (abort > 0 && cnt == abort) begin
        check("busy_mid_clear", 32'(busy), 32'd1);
        return;
      end
      if (busy !== 1'b1) break;
    end
    check("busy_cycles", 32'(cnt), 32'(CLEAR_CYCLES));
    clearing = 1'b0;
  endtask

  initial begin
    // 1: clear after reset, whole array reads zero
    do_reset("rst1");
    clear_run(-1, -1);
    for (int i = 0; i < (1 << AW); i++) cyc(1'b0, 1'b0, 1'b1, AW'(i), '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);

    // 2: single-word writes, read via even and odd address
    cyc(1'b1, 1'b0, 1'b0, 10'd10, 20'h00005);
    cyc(1'b1, 1'b0, 1'b0, 10'd11, 20'h00003);
    cyc(1'b0, 1'b0, 1'b1, 10'd10, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
    check("rvalid_one_cycle", 32'(rvalid), 32'd0);
    check("rdata_holds", 32'(rdata), 32'h00C05);
    cyc(1'b0, 1'b0, 1'b1, 10'd11, '0);

    // 3: pair write at odd address aligns down
    cyc(1'b1, 1'b1, 1'b0, 10'd51, {10'h20B, 10'h288});
    cyc(1'b0, 1'b0, 1'b1, 10'd50, '0);
    cyc(1'b0, 1'b0, 1'b1, 10'd51, '0);

    // 4: same-cycle write and read of the same pair
    cyc(1'b1, 1'b0, 1'b1, 10'd12, 20'h001FF);
    cyc(1'b0, 1'b0, 1'b1, 10'd13, '0);

    // mixed traffic over a small window
    for (int i = 0; i < 80; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          AW'($urandom_range(0, 15)), 20'($urandom()));
    cyc(1'b0, 1'b0, 1'b0, '0, '0);

    // 5: requests during clear are dropped
    do_reset("rst5");
    clear_run(100, -1);
    cyc(1'b0, 1'b0, 1'b1, 10'd20, '0);
    cyc(1'b0, 1'b0, 1'b1, 10'd21, '0);

    // 6: reset mid-traffic, then again mid-clear restarts the full clear
    cyc(1'b1, 1'b0, 1'b0, 10'd2, 20'h0014B);
    cyc(1'b0, 1'b0, 1'b1, 10'd2, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
    do_reset("rst6a");
    clear_run(-1, 300);
    do_reset("rst6b");
    clear_run(-1, -1);
    cyc(1'b0, 1'b0, 1'b1, 10'd2, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);

    check("pending_reads", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
